ram_simple2port_pipe: RTL
=========================

// Module: ram_simple2port_pipe
// PURPOSE
//   Parametrised 1-read/1-write RAM, successor to the plain 2-port store. Adds:
//   - byte-lane write enables
//   - configurable read latency, with a valid strobe
//   - a selectable read-during-write policy
//   - synchronous reset of the read pipeline
//   Sits under the MVU weight/data buffers. Inferred array stays UltraRAM/BRAM-mappable.
// PARAMETERS
//   BDADDR    12       address width; depth = 2**BDADDR words
//   BDWORD    2048     word width (bits)
//   BDLANE    8        bits per write-enable lane; BDWORD % BDLANE == 0
//   RDLAT     2        rd_en -> rd_valid latency in cycles, 1..4
//   RDW_MODE  0        same-cycle same-address collision: 0 = old data, 1 = new (merged) data
// PORTS
//   clk       in   1                  clock, all logic on posedge
//   rst       in   1                  synchronous active-high reset
//   rd_en     in   1                  read request
//   rd_addr   in   BDADDR             read address
//   rd_word   out  BDWORD             read data, registered
//   rd_valid  out  1                  rd_word carries data of the read issued RDLAT cycles earlier
//   wr_en     in   1                  write request
//   wr_addr   in   BDADDR             write address
//   wr_word   in   BDWORD             write data
//   wr_be     in   BDWORD/BDLANE      lane enables; lane i covers bits [i*BDLANE +: BDLANE]
// BEHAVIOUR
//   - Reset:
//     - rd_valid=0, rd_word=0, all internal valid stages=0.
//     - Array contents are NOT reset.
//     - While rst=1, rd_en and wr_en are ignored, so no array write occurs.
//   - Read:
//     - rd_en=1 in cycle T samples the array in T.
//     - Data passes through RDLAT-1 further register stages.
//     - rd_valid=1 and rd_word=data in cycle T+RDLAT.
//     - Fully pipelined: one read per cycle, back-to-back accepted, no stall/backpressure.
//   - rd_word holds its last valid value while rd_valid=0; it changes only on a valid beat.
//   - Write:
//     - wr_en=1 in cycle T updates only lanes with wr_be[i]=1, visible to reads issued at T+1 onward.
//     - wr_be all-zero means no change.
//   - Collision (rd_en & wr_en & rd_addr==wr_addr in the same cycle):
//     - RDW_MODE=0 returns pre-write contents.
//     - RDW_MODE=1 returns the per-lane merge: wr_word where wr_be=1, old data elsewhere. Done by bypass mux at stage 1.
//   - Writes in cycles after T never alter a read already in flight (data is captured at T).
//   - Reset mid-operation: rst in any cycle flushes every in-flight read.
//     - rd_valid=0 on the next edge, until new reads complete RDLAT cycles after rst drops.
//   - Address wrap: none; every address in 0..2**BDADDR-1 is valid.
//   - Elaboration error if RDLAT<1, RDLAT>4, or BDWORD % BDLANE != 0.
// STRUCTURE
//   - ram_pkg:
//     - constants RDW_OLD=0, RDW_NEW=1
//     - function nlanes(word,lane)
//     - lane-merge function merge_be(old,new,be)
//   - One sub-module, ram_rdpipe #(BDWORD, DEPTH=RDLAT-1):
//     - valid+data delay line with sync flush
//     - DEPTH=0 degenerates to a wire
//   - Top holds the inferred array, the lane-masked write, and the collision compare/bypass.
// TESTING
//   1. Reset, then read addr 0 with RDLAT=2 -> rd_valid=0 for 2 cycles, rd_valid=1 at T+2; rd_word=last-written value, not X-driven by logic.
//   2. Write 0xAA..AA to addr 5, wr_be all-ones; next cycle write 0x55 to lane 0 only -> read addr 5 returns 0xAA..AA55.
//   3. Same-cycle read+write addr 7, old=0x1, new=0x2, be all-ones -> RDW_MODE=0 returns 0x1; RDW_MODE=1 returns 0x2.
//   4. Back-to-back reads addr 0..15, RDLAT=3 -> 16 consecutive rd_valid beats in address order, starting at T+3.
//   5. Issue 3 reads, assert rst 1 cycle mid-flight -> no rd_valid for the flushed reads; write issued under rst leaves array unchanged.
//   6. Max address 2**BDADDR-1 write/read, and wr_be=0 write -> data preserved, no aliasing to addr 0.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared constants and helpers for the pipelined simple dual-port RAM.
// Lane merging is written bit-wide so it serves any word width up to MAX_WORD.
package ram_pkg;

    localparam int RDW_OLD  = 0;
    localparam int RDW_NEW  = 1;
    localparam int MAX_WORD = 2048;

    function automatic int nlanes(input int word, input int lane);
        return word / lane;
    endfunction

    // be is lane-indexed: bit k of be governs bits [k*lane +: lane]
    function automatic logic [MAX_WORD-1:0] merge_be(
        input logic [MAX_WORD-1:0] old_word,
        input logic [MAX_WORD-1:0] new_word,
        input logic [MAX_WORD-1:0] be,
        input int                  lane
    );
        logic [MAX_WORD-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_WORD; i++) begin
            merged[i] = be[i / lane] ? new_word[i] : old_word[i];
        end
        return merged;
    endfunction

endpackage

// File: rtl/ram_rdpipe.sv
// Valid+data delay line behind the RAM's first read register.
// Data only advances on a valid beat, so the output word holds between beats.
module ram_rdpipe #(
    parameter int BDWORD = 2048,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BDWORD-1:0] in_word,
    output logic              out_valid,
    output logic [BDWORD-1:0] out_word
);

    if (DEPTH == 0) begin : g_wire
        assign out_valid = in_valid;
        assign out_word  = in_word;
    end else begin : g_pipe
        logic              valid_q [DEPTH];
        logic [BDWORD-1:0] word_q  [DEPTH];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    valid_q[i] <= 1'b0;
                    word_q[i]  <= '0;
                end
            end else begin
                valid_q[0] <= in_valid;
                if (in_valid) begin
                    word_q[0] <= in_word;
                end
                for (int i = 1; i < DEPTH; i++) begin
                    valid_q[i] <= valid_q[i-1];
                    if (valid_q[i-1]) begin
                        word_q[i] <= word_q[i-1];
                    end
                end
            end
        end

        assign out_valid = valid_q[DEPTH-1];
        assign out_word  = word_q[DEPTH-1];
    end

endmodule

// File: rtl/ram_simple2port_pipe.sv
// 1-read/1-write RAM with byte-lane writes, RDLAT-cycle read pipeline and
// selectable read-during-write result; the array itself is never reset.
module ram_simple2port_pipe
    import ram_pkg::*;
#(
    parameter int BDADDR   = 12,
    parameter int BDWORD   = 2048,
    parameter int BDLANE   = 8,
    parameter int RDLAT    = 2,
    parameter int RDW_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic [BDADDR-1:0]        rd_addr,
    output logic [BDWORD-1:0]        rd_word,
    output logic                     rd_valid,
    input  logic                     wr_en,
    input  logic [BDADDR-1:0]        wr_addr,
    input  logic [BDWORD-1:0]        wr_word,
    input  logic [BDWORD/BDLANE-1:0] wr_be
);

    localparam int NLANES = nlanes(BDWORD, BDLANE);
    localparam int DEPTH  = 2 ** BDADDR;

    if (RDLAT < 1 || RDLAT > 4) begin : g_bad_rdlat
        $error("ram_simple2port_pipe: RDLAT must be within 1..4");
    end
    if (BDWORD % BDLANE != 0) begin : g_bad_lane
        $error("ram_simple2port_pipe: BDWORD must be a multiple of BDLANE");
    end
    if (BDWORD > MAX_WORD) begin : g_bad_word
        $error("ram_simple2port_pipe: BDWORD exceeds ram_pkg::MAX_WORD");
    end

    logic [BDWORD-1:0]   mem [DEPTH];
    logic [BDWORD-1:0]   old_word;
    logic [BDWORD-1:0]   merged_word;
    logic [MAX_WORD-1:0] merged_wide;
    logic                collide;
    logic                s1_valid;
    logic [BDWORD-1:0]   s1_word;

    assign old_word    = mem[rd_addr];
    assign collide     = wr_en && (rd_addr == wr_addr);
    assign merged_wide = merge_be(MAX_WORD'(old_word), MAX_WORD'(wr_word),
                                  MAX_WORD'(wr_be), BDLANE);
    assign merged_word = merged_wide[BDWORD-1:0];

    // Array write, lane by lane; suppressed entirely while in reset
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            for (int i = 0; i < NLANES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*BDLANE +: BDLANE] <= wr_word[i*BDLANE +: BDLANE];
                end
            end
        end
    end

    // First read stage; the collision bypass lives here so later stages only delay
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_word  <= '0;
        end else begin
            s1_valid <= rd_en;
            if (rd_en) begin
                s1_word <= (RDW_MODE == RDW_NEW && collide) ? merged_word : old_word;
            end
        end
    end

    ram_rdpipe #(
        .BDWORD (BDWORD),
        .DEPTH  (RDLAT - 1)
    ) u_rdpipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_word   (s1_word),
        .out_valid (rd_valid),
        .out_word  (rd_word)
    );

endmodule
